// File: rtl/mem_access_stage.sv
// Pipeline memory stage: data-memory req/ready access with a wait-state timeout, branch resolution, MEM/WB register.
// Optional macro MEM_MISALIGN_CHECK_EN blocks word-misaligned accesses and adds a sticky misalign flag.
module mem_access_stage #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] store_data_in,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  dest_in,
  input  logic [3:0]  memctrl_in,
  input  logic [1:0]  wbctrl_in,
  input  logic [31:0] addresult_in,
  input  logic        zero_in,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        wb_valid,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dest,
  output logic [1:0]  wb_ctrl,
  output logic        mem_err,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        state_dbg
);

  // Handshake: mem_rd/mem_wr act as valid and are held, with address and data
  // stable, until the cycle mem_ready=1 (that cycle completes the transfer).
  // mem_ready outside a request is ignored. Upstream holds while stall=1.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mem_read, mem_write, access, misaligned, req, timeout, complete;

  assign mem_read  = memctrl_in[3];
  assign mem_write = memctrl_in[2];
  assign access    = in_valid & (mem_read | mem_write);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = access & (alu_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign req      = access & ~misaligned;
  assign timeout  = (state == S_WAIT) & ~mem_ready & (cnt == LIMIT);
  assign complete = req & (mem_ready | timeout);

  assign state_dbg     = (state == S_WAIT);
  assign branch_target = addresult_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req && !mem_ready) state_nxt = S_WAIT;
      S_WAIT: if (!req || mem_ready || timeout) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read wins when MemRead and MemWrite are both set; rst drops the request at once.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    if (!rst && req) begin
      mem_rd    = mem_read;
      mem_wr    = mem_write & ~mem_read;
      mem_addr  = alu_result_in;
      mem_wdata = store_data_in;
      stall     = ~complete;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= (req && !mem_ready) ? CNT_W'(1) : '0;
    end else if (state_nxt == S_WAIT) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    if (!rst && in_valid && !stall) begin
      case (memctrl_in[1:0])
        2'b01:   branch_taken = zero_in;
        2'b10:   branch_taken = ~zero_in;
        2'b11:   branch_taken = 1'b1;
        default: branch_taken = 1'b0;
      endcase
    end
  end

  // An aborted or blocked access still retires, but never writes the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_read_data <= '0;
      wb_result    <= '0;
      wb_dest      <= '0;
      wb_ctrl      <= '0;
      mem_err      <= 1'b0;
    end else begin
      mem_err <= mem_err | timeout;
      if (in_valid && !stall) begin
        wb_valid     <= 1'b1;
        wb_result    <= alu_result_in;
        wb_dest      <= dest_in;
        wb_ctrl      <= {wbctrl_in[1] & ~timeout & ~misaligned, wbctrl_in[0]};
        wb_read_data <= (req && mem_read && !timeout) ? mem_rdata : '0;
      end else begin
        wb_valid <= 1'b0;
        wb_ctrl  <= '0;
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= misalign | misaligned;
  end
`endif

endmodule
